// File: rtl/axi_master_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM state encoding and xRESP codes.
package axi_master_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t IDLE    = 3'd0;
    localparam fsm_state_t RD_ADDR = 3'd1;
    localparam fsm_state_t RD_DATA = 3'd2;
    localparam fsm_state_t WR_REQ  = 3'd3;
    localparam fsm_state_t WR_RESP = 3'd4;
    localparam fsm_state_t RESP    = 3'd5;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_valid_hold.sv
// Holds one AXI VALID from start until its READY handshake, then raises done
// until the next start.
module axi_valid_hold (
    input  logic CLK,
    input  logic RESETN,
    input  logic start,
    input  logic ready,
    output logic valid,
    output logic done
);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            valid <= 1'b1;
            done  <= 1'b0;
        end else if (valid && ready) begin
            valid <= 1'b0;
            done  <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master with registered AXI outputs.
// Optional macro AXI_MASTER_RESP_EN: report captured RRESP/BRESP on RSP_ERR.
module axi_lite_master_ctrl
    import axi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic                    REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
    input  logic [DATA_WIDTH/8-1:0] REQ_WMASK,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]              RSP_ERR,
    output logic [ADDR_WIDTH-1:0]   AW_ADDR,
    output logic                    AW_VALID,
    input  logic                    AW_READY,
    output logic [DATA_WIDTH-1:0]   W_DATA,
    output logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    W_VALID,
    input  logic                    W_READY,
    input  logic [1:0]              B_RESP,
    input  logic                    B_VALID,
    output logic                    B_READY,
    output logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic                    AR_VALID,
    input  logic                    AR_READY,
    input  logic [DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]              R_RESP,
    input  logic                    R_VALID,
    output logic                    R_READY
);

    fsm_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept;
    logic                  wr_start;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_finished;
    logic                  w_finished;
    logic                  rd_capture;
    logic                  wr_capture;

    assign accept      = (state == IDLE) && REQ_VALID && REQ_READY;
    assign wr_start    = accept && REQ_WRITE;
    assign aw_finished = aw_done || (AW_VALID && AW_READY);
    assign w_finished  = w_done || (W_VALID && W_READY);
    assign rd_capture  = (state == RD_DATA) && R_VALID;
    assign wr_capture  = (state == WR_RESP) && B_VALID;

    // One latched address feeds both channels; only the active one raises VALID.
    assign AW_ADDR = addr_q;
    assign AR_ADDR = addr_q;

    axi_valid_hold u_aw_hold (
        .CLK    (CLK),
        .RESETN (RESETN),
        .start  (wr_start),
        .ready  (AW_READY),
        .valid  (AW_VALID),
        .done   (aw_done)
    );

    axi_valid_hold u_w_hold (
        .CLK    (CLK),
        .RESETN (RESETN),
        .start  (wr_start),
        .ready  (W_READY),
        .valid  (W_VALID),
        .done   (w_done)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= IDLE;
            REQ_READY <= 1'b1;
            AR_VALID  <= 1'b0;
            R_READY   <= 1'b0;
            B_READY   <= 1'b0;
            RSP_VALID <= 1'b0;
            addr_q    <= '0;
            W_DATA    <= '0;
            W_STRB    <= '0;
            RSP_RDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        REQ_READY <= 1'b0;
                        addr_q    <= REQ_ADDR;
                        W_DATA    <= REQ_WDATA;
                        W_STRB    <= REQ_WMASK;
                        if (REQ_WRITE) begin
                            state <= WR_REQ;
                        end else begin
                            AR_VALID <= 1'b1;
                            state    <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (AR_READY) begin
                        AR_VALID <= 1'b0;
                        R_READY  <= 1'b1;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (R_VALID) begin
                        R_READY   <= 1'b0;
                        RSP_RDATA <= R_DATA;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                // AW and W may complete in either order or in the same cycle.
                WR_REQ: begin
                    if (aw_finished && w_finished) begin
                        B_READY <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (B_VALID) begin
                        B_READY   <= 1'b0;
                        RSP_RDATA <= '0;
                        RSP_VALID <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        REQ_READY <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    REQ_READY <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef AXI_MASTER_RESP_EN
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            RSP_ERR <= OKAY;
        end else if (rd_capture) begin
            RSP_ERR <= R_RESP;
        end else if (wr_capture) begin
            RSP_ERR <= B_RESP;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{B_RESP, R_RESP, rd_capture, wr_capture};
    assign RSP_ERR     = 2'b00;
`endif

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Self-checking bench for axi_lite_master_ctrl: directed AXI slave stimulus with
// a response scoreboard. Honours AXI_MASTER_RESP_EN when predicting RSP_ERR.
module tb_axi_lite_master_ctrl;
    import axi_master_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

`ifdef AXI_MASTER_RESP_EN
    localparam logic [1:0] ERR_MASK = 2'b11;
`else
    localparam logic [1:0] ERR_MASK = 2'b00;
`endif

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic [DW/8-1:0] REQ_WMASK;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [DW-1:0] RSP_RDATA;
    logic [1:0]    RSP_ERR;
    logic [AW-1:0] AW_ADDR;
    logic          AW_VALID;
    logic          AW_READY;
    logic [DW-1:0] W_DATA;
    logic [DW/8-1:0] W_STRB;
    logic          W_VALID;
    logic          W_READY;
    logic [1:0]    B_RESP;
    logic          B_VALID;
    logic          B_READY;
    logic [AW-1:0] AR_ADDR;
    logic          AR_VALID;
    logic          AR_READY;
    logic [DW-1:0] R_DATA;
    logic [1:0]    R_RESP;
    logic          R_VALID;
    logic          R_READY;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   b_hs_count = 0;

    axi_lite_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WMASK(REQ_WMASK),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (B_VALID && B_READY) b_hs_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one core request and records the response the core should see.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [DW/8-1:0] wmask, input logic [DW-1:0] exp_rdata,
                                 input logic [1:0] slave_resp);
        exp_t e;
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        REQ_WMASK = wmask;
        e.rdata   = exp_rdata;
        e.err     = slave_resp & ERR_MASK;
        exp_q.push_back(e);
    endtask

    task automatic collectResponse(input string tag);
        exp_t e;
        int   waited = 0;
        while (!RSP_VALID && waited < 20) begin
            step();
            waited++;
        end
        if (!RSP_VALID) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, "_rdata"}, RSP_RDATA, e.rdata);
            checkOutput({tag, "_err"}, {62'd0, RSP_ERR}, {62'd0, e.err});
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        checkOutput({tag, "_rsp_clr"}, {63'd0, RSP_VALID}, 64'd0);
        checkOutput({tag, "_req_ready"}, {63'd0, REQ_READY}, 64'd1);
    endtask

    task automatic clearSlave();
        AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = OKAY;
        AR_READY = 1'b0; R_VALID = 1'b0; R_RESP = OKAY; R_DATA = '0;
    endtask

    initial begin
        int b_start;
        RESETN = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0;
        REQ_WDATA = '0; REQ_WMASK = '0; RSP_READY = 1'b0;
        clearSlave();
        step();
        step();
        checkOutput("rst_req_ready", {63'd0, REQ_READY}, 64'd1);
        checkOutput("rst_valids", {59'd0, AW_VALID, W_VALID, AR_VALID, RSP_VALID, 1'b0}, 64'd0);
        checkOutput("rst_readys", {62'd0, B_READY, R_READY}, 64'd0);
        checkOutput("rst_addrs", AW_ADDR | AR_ADDR, 64'd0);
        checkOutput("rst_wdata", W_DATA | {56'd0, W_STRB}, 64'd0);
        checkOutput("rst_rsp", RSP_RDATA | {62'd0, RSP_ERR}, 64'd0);
        RESETN = 1'b1;
        step();

        // Read, slave always ready: 3-cycle latency
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 64'h1122334455667788; R_RESP = OKAY;
        applyStimulus(1'b0, 64'h8000_0010, '0, '0, 64'h1122334455667788, OKAY);
        step();
        REQ_VALID = 1'b0;
        checkOutput("rd1_ar_valid_c1", {63'd0, AR_VALID}, 64'd1);
        checkOutput("rd1_ar_addr", AR_ADDR, 64'h8000_0010);
        step();
        checkOutput("rd1_ar_valid_c2", {63'd0, AR_VALID}, 64'd0);
        checkOutput("rd1_r_ready_c2", {63'd0, R_READY}, 64'd1);
        step();
        checkOutput("rd1_rsp_valid_c3", {63'd0, RSP_VALID}, 64'd1);
        checkOutput("rd1_r_ready_c3", {63'd0, R_READY}, 64'd0);
        clearSlave();
        collectResponse("rd1");

        // Write: W_READY at cycle 1, AW_READY at cycle 4
        W_READY = 1'b1;
        b_start = b_hs_count;
        applyStimulus(1'b1, 64'h8000_0100, 64'hDEADBEEF, 8'h0F, 64'd0, OKAY);
        step();
        REQ_VALID = 1'b0;
        checkOutput("wr_valids_c1", {62'd0, AW_VALID, W_VALID}, 64'd3);
        checkOutput("wr_strb", {56'd0, W_STRB}, 64'h0F);
        checkOutput("wr_data", W_DATA, 64'hDEADBEEF);
        checkOutput("wr_aw_addr", AW_ADDR, 64'h8000_0100);
        step();
        W_READY = 1'b0;
        checkOutput("wr_valids_c2", {62'd0, AW_VALID, W_VALID}, 64'd2);
        step();
        checkOutput("wr_b_ready_c3", {63'd0, B_READY}, 64'd0);
        step();
        AW_READY = 1'b1;
        checkOutput("wr_aw_valid_c4", {63'd0, AW_VALID}, 64'd1);
        step();
        AW_READY = 1'b0;
        checkOutput("wr_aw_valid_c5", {63'd0, AW_VALID}, 64'd0);
        checkOutput("wr_b_ready_c5", {63'd0, B_READY}, 64'd1);
        B_VALID = 1'b1; B_RESP = OKAY;
        step();
        checkOutput("wr_b_ready_c6", {63'd0, B_READY}, 64'd0);
        B_VALID = 1'b0;
        collectResponse("wr1");
        checkOutput("wr_b_handshakes", b_hs_count - b_start, 64'd1);

        // Read with SLVERR and a stalled core response
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 64'hCAFEF00D12345678; R_RESP = SLVERR;
        applyStimulus(1'b0, 64'h0000_1000, '0, '0, 64'hCAFEF00D12345678, SLVERR);
        step();
        REQ_VALID = 1'b0;
        step();
        step();
        clearSlave();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rsp_valid", {63'd0, RSP_VALID}, 64'd1);
            checkOutput("stall_rdata", RSP_RDATA, 64'hCAFEF00D12345678);
            checkOutput("stall_err", {62'd0, RSP_ERR}, {62'd0, SLVERR & ERR_MASK});
            checkOutput("stall_req_ready", {63'd0, REQ_READY}, 64'd0);
            step();
        end
        collectResponse("rd_err");

        // Back-to-back write then read with REQ_VALID held high
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = EXOKAY;
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 64'h0123456789ABCDEF; R_RESP = OKAY;
        applyStimulus(1'b1, 64'h0000_2000, 64'h5555AAAA5555AAAA, 8'hFF, 64'd0, EXOKAY);
        step();
        applyStimulus(1'b0, 64'h0000_3008, '0, '0, 64'h0123456789ABCDEF, OKAY);
        collectResponse("b2b_wr");
        step();
        REQ_VALID = 1'b0;
        checkOutput("b2b_ar_valid", {63'd0, AR_VALID}, 64'd1);
        checkOutput("b2b_ar_addr", AR_ADDR, 64'h0000_3008);
        collectResponse("b2b_rd");
        clearSlave();

        // Reset while in RD_DATA drops the transaction
        AR_READY = 1'b1;
        applyStimulus(1'b0, 64'h0000_5000, '0, '0, 64'd0, OKAY);
        step();
        REQ_VALID = 1'b0;
        step();
        checkOutput("rst_mid_r_ready", {63'd0, R_READY}, 64'd1);
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        exp_q.delete();
        checkOutput("rst_mid_valids", {60'd0, AW_VALID, W_VALID, AR_VALID, RSP_VALID}, 64'd0);
        checkOutput("rst_mid_readys", {62'd0, B_READY, R_READY}, 64'd0);
        checkOutput("rst_mid_req_ready", {63'd0, REQ_READY}, 64'd1);
        checkOutput("rst_mid_ar_addr", AR_ADDR, 64'd0);

        // Following read: R_VALID early, AR_READY late
        clearSlave();
        R_VALID = 1'b1; R_DATA = 64'hA5A5A5A5_5A5A5A5A; R_RESP = DECERR;
        applyStimulus(1'b0, 64'h4000_0008, '0, '0, 64'hA5A5A5A5_5A5A5A5A, DECERR);
        step();
        REQ_VALID = 1'b0;
        checkOutput("post_rst_ar_valid", {63'd0, AR_VALID}, 64'd1);
        checkOutput("post_rst_r_ready_early", {63'd0, R_READY}, 64'd0);
        step();
        AR_READY = 1'b1;
        step();
        AR_READY = 1'b0;
        checkOutput("post_rst_r_ready", {63'd0, R_READY}, 64'd1);
        collectResponse("post_rst_rd");
        clearSlave();

        // Request inputs ignored while AR is pending
        applyStimulus(1'b0, 64'h0000_2000, '0, '0, 64'h7777_8888_9999_AAAA, OKAY);
        step();
        for (int i = 0; i < 4; i++) begin
            REQ_VALID = (i % 2 == 0);
            REQ_ADDR  = 64'h0000_9000 + 64'(i);
            checkOutput("hold_ar_addr", AR_ADDR, 64'h0000_2000);
            checkOutput("hold_ar_valid", {63'd0, AR_VALID}, 64'd1);
            checkOutput("hold_req_ready", {63'd0, REQ_READY}, 64'd0);
            step();
        end
        REQ_VALID = 1'b0;
        AR_READY = 1'b1;
        checkOutput("hold_ar_addr_hs", AR_ADDR, 64'h0000_2000);
        step();
        AR_READY = 1'b0;
        checkOutput("hold_ar_done", {63'd0, AR_VALID}, 64'd0);
        R_VALID = 1'b1; R_DATA = 64'h7777_8888_9999_AAAA; R_RESP = OKAY;
        collectResponse("hold_rd");
        clearSlave();

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
